// File: rtl/fifo_wide_to_narrow.sv
// -----------------------------------------------------------------------------
// fifo_wide_to_narrow
//
// Width-down-converting FIFO. IN_W-bit words are buffered in a DEPTH-entry
// storage array and then emitted as RATIO = IN_W/OUT_W consecutive OUT_W-bit
// chunks through a single output holding register. Both sides use a
// valid/ready handshake. Back-to-back words stream with no idle cycle between
// the last chunk of one word and chunk 0 of the next.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   flush      synchronous clear of all stored and in-flight data
//   in_valid   producer has a word on in_data
//   in_ready   a word can be accepted (= !full)
//   in_data    IN_W-bit input word
//   out_valid  out_data holds a valid chunk
//   out_ready  consumer accepts the current chunk
//   out_data   current OUT_W-bit chunk
//   out_last   current chunk is the final chunk of its word
//   count      words held in the storage array (holding register excluded)
//   full       count == DEPTH
//   empty      count == 0 and no chunk pending at the output
//
// Parameters
//   IN_W       input word width, an integer multiple of OUT_W
//   OUT_W      output chunk width
//   DEPTH      storage words, power of two, >= 2
//   MSB_FIRST  0: bits [OUT_W-1:0] go first; 1: bits [IN_W-1:IN_W-OUT_W] first
// -----------------------------------------------------------------------------
module fifo_wide_to_narrow #(
  parameter int IN_W      = 128,
  parameter int OUT_W     = 32,
  parameter int DEPTH     = 16,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IN_W-1:0]          in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_data,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int RATIO = IN_W / OUT_W;
  localparam int AW    = $clog2(DEPTH);   // storage index width
  localparam int PW    = AW + 1;          // pointer width, MSB is the wrap bit
  localparam int IW    = $clog2(RATIO);   // chunk index width

  localparam logic [IW-1:0] LAST_IDX = IW'(RATIO - 1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);

  // Storage and pointers
  logic [IN_W-1:0] mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  // Output stage
  logic [IN_W-1:0] hold_q;
  logic [IW-1:0]   idx_q;
  logic            valid_q;

  // Derived control
  logic            wr_en;
  logic            mem_has_word;
  logic            last_taken;
  logic            load;
  logic [IW-1:0]   sel;

  // NOTE: status comes purely from registered pointers and valid_q, so there
  // is no combinational path from out_ready to in_ready/full/empty. A pop
  // in the same cycle therefore never opens space for a write.
  assign count        = wr_ptr - rd_ptr;
  assign full         = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign mem_has_word = (wr_ptr != rd_ptr);
  assign empty        = !mem_has_word && !valid_q;
  assign in_ready     = !full;

  assign wr_en      = in_valid && !full;
  assign out_valid  = valid_q;
  assign out_last   = valid_q && (idx_q == LAST_IDX);
  assign last_taken = out_last && out_ready;

  // Refill the holding register when it is idle or its last chunk is being
  // taken this cycle; this is what removes the bubble between words.
  assign load = mem_has_word && (!valid_q || last_taken);

  // With RATIO a power of two, RATIO-1-idx is simply the bitwise inverse.
  assign sel      = MSB_FIRST ? ~idx_q : idx_q;
  assign out_data = hold_q[sel*OUT_W +: OUT_W];

  // NOTE: the storage array has no reset; only the pointers define which
  // entries are live, so clearing it would cost logic for no behaviour.
  always_ff @(posedge clk) begin
    if (!rst && !flush && wr_en) begin
      mem[wr_ptr[AW-1:0]] <= in_data;
    end
  end

  // Pointers and output stage. Flush acts like reset on all datapath state
  // and overrides any write or pop presented in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      hold_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end

      if (load) begin
        hold_q  <= mem[rd_ptr[AW-1:0]];
        idx_q   <= '0;
        valid_q <= 1'b1;
        rd_ptr  <= rd_ptr + PTR_ONE;
      end else if (valid_q && out_ready) begin
        if (out_last) begin
          // Last chunk taken and nothing stored behind it.
          valid_q <= 1'b0;
          idx_q   <= '0;
        end else begin
          idx_q <= idx_q + IDX_ONE;
        end
      end
    end
  end

endmodule
